// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and ACK/NACK bit values.
// The master reuses the encodings for the state names it has in common.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_ADDR      = ST_ADDR,
        S_ADDR_ACK  = ST_ADDR_ACK,
        S_PTR       = ST_PTR,
        S_PTR_ACK   = ST_PTR_ACK,
        S_WDATA     = ST_WDATA,
        S_WDATA_ACK = ST_WDATA_ACK,
        S_RDATA     = ST_RDATA,
        S_RDATA_ACK = ST_RDATA_ACK
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA 2-FF synchronizers + history register; START/STOP/SCL-edge pulses, 2 clk + comb decode.
// No backpressure: pulses are single-cycle and must be consumed when asserted.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;
    logic       scl_s;

    // Reset to the idle-bus level so a released bus never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high on both samples, so a simultaneous SCL/SDA drop is not a START.
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with auto-incrementing byte register file; decisions 3 clk after pad, SDA updated 1 clk after SCL fall.
// No backpressure: never stretches SCL; fabric sees writes as wr_strobe pulses, reads via host_addr/host_rdata.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDRESS = 7'h76,
    parameter int         NUM_REGS       = 16,
    parameter int         PTR_W          = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e       state_d, state_q;
    logic [2:0]       bit_cnt_d, bit_cnt_q;
    logic [7:0]       sh_d, sh_q;
    logic [PTR_W-1:0] ptr_d, ptr_q;
    logic             sda_oe_d, sda_oe_q;
    logic             busy_d, busy_q;
    logic             wr_strobe_d, wr_strobe_q;
    logic [PTR_W-1:0] wr_addr_d, wr_addr_q;
    logic [7:0]       wr_data_d, wr_data_q;
    logic             reg_we;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;

    assign rx_byte = {sh_q[6:0], sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ADDR, S_PTR, S_WDATA: begin
                    // bit_cnt wraps 7 -> 0 on the last bit, ready for the ACK phase.
                    if (scl_rise) begin
                        sh_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDRESS) begin
                                    state_d = S_ADDR_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte[PTR_W-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                reg_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_q + PTR_W'(1);
                                state_d     = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    // First fall starts the ACK drive, second fall ends it.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d  = ~ACK_BIT;
                            bit_cnt_d = 3'd1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            if (state_q == S_ADDR_ACK && sh_q[0]) begin
                                sh_d     = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                                state_d  = S_RDATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                if (state_q == S_ADDR_ACK) begin
                                    state_d = S_PTR;
                                end else begin
                                    state_d = S_WDATA;
                                end
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + PTR_W'(1);
                            bit_cnt_d = 3'd0;
                            state_d   = S_RDATA_ACK;
                        end else begin
                            sh_d      = {sh_q[6:0], 1'b0};
                            sda_oe_d  = ~sh_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (bit_cnt_q == 3'd0) begin
                        if (scl_rise) begin
                            if (sda_s == NACK_BIT) begin
                                state_d = S_IDLE;
                            end else begin
                                bit_cnt_d = 3'd1;
                            end
                        end
                    end else if (scl_fall) begin
                        sh_d      = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 3'd0;
                        state_d   = S_RDATA;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign host_rdata = regs_q[host_addr];
    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule
